// File: rtl/cva6_regfile_mt_if.sv
// Issue/commit-side bundle for the multi-threaded register file: read ports,
// commit write ports, bank-clear control and status flags.
interface cva6_regfile_mt_if #(
    parameter int unsigned DATA_WIDTH     = 32'd32,
    parameter int unsigned NR_REGS        = 32'd32,
    parameter int unsigned NR_THREADS     = 32'd2,
    parameter int unsigned NR_READ_PORTS  = 32'd2,
    parameter int unsigned NR_WRITE_PORTS = 32'd2
);
    localparam int unsigned AW = $clog2(NR_REGS);
    localparam int unsigned TW = (NR_THREADS > 32'd1) ? $clog2(NR_THREADS) : 32'd1;

    logic [NR_READ_PORTS-1:0][AW-1:0]          raddr_i;
    logic [NR_READ_PORTS-1:0][TW-1:0]          rtid_i;
    logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_o;
    logic [NR_WRITE_PORTS-1:0]                 we_i;
    logic [NR_WRITE_PORTS-1:0][AW-1:0]         waddr_i;
    logic [NR_WRITE_PORTS-1:0][TW-1:0]         wtid_i;
    logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wdata_i;
    logic                                      clear_req_i;
    logic [TW-1:0]                             clear_tid_i;
    logic                                      clear_busy_o;
    logic                                      clear_done_o;
    logic [NR_WRITE_PORTS-1:0]                 wr_drop_o;
    logic                                      collision_o;

    modport master (
        output raddr_i, rtid_i, we_i, waddr_i, wtid_i, wdata_i, clear_req_i, clear_tid_i,
        input  rdata_o, clear_busy_o, clear_done_o, wr_drop_o, collision_o
    );

    modport slave (
        input  raddr_i, rtid_i, we_i, waddr_i, wtid_i, wdata_i, clear_req_i, clear_tid_i,
        output rdata_o, clear_busy_o, clear_done_o, wr_drop_o, collision_o
    );
endinterface

// File: rtl/cva6_regfile_mt.sv
// Flip-flop register file with one bank per hardware thread, highest-port-wins
// write arbitration, optional write-to-read bypass and a sequential bank clear.
module cva6_regfile_mt #(
    parameter int unsigned DATA_WIDTH     = 32'd32,
    parameter int unsigned NR_REGS        = 32'd32,
    parameter int unsigned NR_THREADS     = 32'd2,
    parameter int unsigned NR_READ_PORTS  = 32'd2,
    parameter int unsigned NR_WRITE_PORTS = 32'd2,
    parameter bit          ZERO_REG_ZERO  = 1'b1,
    parameter bit          BYPASS         = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    cva6_regfile_mt_if.slave       rf
);
    localparam int unsigned AW = $clog2(NR_REGS);
    localparam int unsigned TW = (NR_THREADS > 32'd1) ? $clog2(NR_THREADS) : 32'd1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    logic [DATA_WIDTH-1:0]                     mem_r [NR_THREADS][NR_REGS];
    state_e                                    state_r;
    logic [AW-1:0]                             cnt_r;
    logic [TW-1:0]                             clear_tid_r;
    logic                                      done_r;
    logic [NR_WRITE_PORTS-1:0]                 wr_drop_r;
    logic                                      collision_r;

    logic [NR_WRITE_PORTS-1:0]                 drop_s;
    logic [NR_WRITE_PORTS-1:0]                 commit_s;
    logic [NR_WRITE_PORTS-1:0]                 win_s;
    logic                                      collision_s;
    logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]  rdata_s;

    function automatic logic idx_ok(input logic [AW-1:0] idx);
        return 32'(idx) < NR_REGS;
    endfunction

    function automatic logic tid_ok(input logic [TW-1:0] tid);
        return 32'(tid) < NR_THREADS;
    endfunction

    // Classify each write port, then let the highest-numbered port claim a shared target
    always_comb begin
        drop_s      = '0;
        commit_s    = '0;
        win_s       = '0;
        collision_s = 1'b0;
        for (int p = 0; p < int'(NR_WRITE_PORTS); p++) begin
            if (!rf.we_i[p]) begin
                commit_s[p] = 1'b0;
            end else if (!idx_ok(rf.waddr_i[p]) || !tid_ok(rf.wtid_i[p]) ||
                         (state_r == CLEAR && rf.wtid_i[p] == clear_tid_r)) begin
                drop_s[p] = 1'b1;
            end else if (ZERO_REG_ZERO && rf.waddr_i[p] == AW'(0)) begin
                commit_s[p] = 1'b0;
            end else begin
                commit_s[p] = 1'b1;
            end
        end
        for (int p = 0; p < int'(NR_WRITE_PORTS); p++) begin
            win_s[p] = commit_s[p];
            for (int q = p + 1; q < int'(NR_WRITE_PORTS); q++) begin
                if (rf.we_i[p] && rf.we_i[q] && rf.wtid_i[p] == rf.wtid_i[q] &&
                    rf.waddr_i[p] == rf.waddr_i[q]) begin
                    win_s[p]    = 1'b0;
                    collision_s = 1'b1;
                end else begin
                    win_s[p] = win_s[p];
                end
            end
        end
    end

    // Read mux: invalid targets and x0 read zero; a winning same-cycle write is forwarded
    always_comb begin
        rdata_s = '0;
        for (int r = 0; r < int'(NR_READ_PORTS); r++) begin
            if (tid_ok(rf.rtid_i[r]) && idx_ok(rf.raddr_i[r]) &&
                !(ZERO_REG_ZERO && rf.raddr_i[r] == AW'(0))) begin
                rdata_s[r] = mem_r[rf.rtid_i[r]][rf.raddr_i[r]];
                for (int p = 0; p < int'(NR_WRITE_PORTS); p++) begin
                    if (BYPASS && win_s[p] && rf.wtid_i[p] == rf.rtid_i[r] &&
                        rf.waddr_i[p] == rf.raddr_i[r]) begin
                        rdata_s[r] = rf.wdata_i[p];
                    end else begin
                        rdata_s[r] = rdata_s[r];
                    end
                end
            end else begin
                rdata_s[r] = '0;
            end
        end
    end

    // Storage update: commit writes never target the bank the clear engine owns
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int t = 0; t < int'(NR_THREADS); t++) begin
                for (int i = 0; i < int'(NR_REGS); i++) begin
                    mem_r[t][i] <= '0;
                end
            end
        end else begin
            for (int p = 0; p < int'(NR_WRITE_PORTS); p++) begin
                if (win_s[p]) begin
                    mem_r[rf.wtid_i[p]][rf.waddr_i[p]] <= rf.wdata_i[p];
                end
            end
            if (state_r == CLEAR && tid_ok(clear_tid_r)) begin
                mem_r[clear_tid_r][cnt_r] <= '0;
            end
        end
    end

    // Clear engine and registered status flags; done is pre-computed one cycle ahead
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= IDLE;
            cnt_r       <= '0;
            clear_tid_r <= '0;
            done_r      <= 1'b0;
            wr_drop_r   <= '0;
            collision_r <= 1'b0;
        end else begin
            wr_drop_r   <= drop_s;
            collision_r <= collision_s;
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (rf.clear_req_i) begin
                        state_r     <= CLEAR;
                        clear_tid_r <= rf.clear_tid_i;
                        cnt_r       <= '0;
                    end
                end
                CLEAR: begin
                    if (cnt_r == AW'(NR_REGS - 32'd1)) begin
                        state_r <= IDLE;
                        cnt_r   <= '0;
                        done_r  <= 1'b0;
                    end else begin
                        cnt_r  <= cnt_r + AW'(1);
                        done_r <= (cnt_r == AW'(NR_REGS - 32'd2));
                    end
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign rf.rdata_o      = rdata_s;
    assign rf.clear_busy_o = (state_r == CLEAR);
    assign rf.clear_done_o = done_r;
    assign rf.wr_drop_o    = wr_drop_r;
    assign rf.collision_o  = collision_r;
endmodule

// File: tb/tb_cva6_regfile_mt.sv
// Randomised bench for cva6_regfile_mt against an array-based model of the
// register-file rules, plus directed scenarios for clear, bypass and reset.
module tb_cva6_regfile_mt;
    localparam int unsigned DW    = 32;
    localparam int unsigned NREGS = 32;
    localparam int unsigned NTH   = 2;
    localparam int unsigned NRP   = 2;
    localparam int unsigned NWP   = 2;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    cva6_regfile_mt_if #(.DATA_WIDTH(DW), .NR_REGS(NREGS), .NR_THREADS(NTH),
                         .NR_READ_PORTS(NRP), .NR_WRITE_PORTS(NWP)) bus ();

    cva6_regfile_mt #(.DATA_WIDTH(DW), .NR_REGS(NREGS), .NR_THREADS(NTH),
                      .NR_READ_PORTS(NRP), .NR_WRITE_PORTS(NWP),
                      .ZERO_REG_ZERO(1'b1), .BYPASS(1'b1)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rf    (bus)
    );

    int n_checks, n_errors, n_busy, n_done;

    logic [31:0]    m_mem [NTH][NREGS];
    bit             m_busy;
    int             m_ctid, m_cnt;
    logic [NWP-1:0] m_drop;
    logic           m_coll;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int t = 0; t < NTH; t++)
            for (int r = 0; r < NREGS; r++) m_mem[t][r] = 32'd0;
        m_busy = 1'b0; m_ctid = 0; m_cnt = 0; m_drop = '0; m_coll = 1'b0;
    endfunction

    function automatic bit port_dropped(int p);
        return bus.we_i[p] && m_busy && int'(bus.wtid_i[p]) == m_ctid;
    endfunction

    // Register value seen by a read: later ports overwrite earlier ones, so the highest wins
    function automatic logic [31:0] ref_read(int tid, int idx);
        logic [31:0] v;
        if (idx == 0 || idx >= NREGS || tid >= NTH) return 32'd0;
        v = m_mem[tid][idx];
        for (int p = 0; p < NWP; p++)
            if (bus.we_i[p] && !port_dropped(p) && int'(bus.wtid_i[p]) == tid &&
                int'(bus.waddr_i[p]) == idx) v = bus.wdata_i[p];
        return v;
    endfunction

    function automatic void model_edge();
        logic [NWP-1:0] nd;
        logic nc;
        if (rst_i) begin
            model_reset();
            return;
        end
        nd = '0; nc = 1'b0;
        for (int p = 0; p < NWP; p++) nd[p] = port_dropped(p);
        for (int p = 0; p < NWP; p++)
            for (int q = p + 1; q < NWP; q++)
                if (bus.we_i[p] && bus.we_i[q] && bus.wtid_i[p] == bus.wtid_i[q] &&
                    bus.waddr_i[p] == bus.waddr_i[q]) nc = 1'b1;
        for (int p = 0; p < NWP; p++)
            if (bus.we_i[p] && !nd[p] && bus.waddr_i[p] != 5'd0)
                m_mem[bus.wtid_i[p]][bus.waddr_i[p]] = bus.wdata_i[p];
        if (m_busy) begin
            m_mem[m_ctid][m_cnt] = 32'd0;
            if (m_cnt == NREGS - 1) m_busy = 1'b0;
            else m_cnt++;
        end else if (bus.clear_req_i) begin
            m_busy = 1'b1; m_ctid = int'(bus.clear_tid_i); m_cnt = 0;
        end
        m_drop = nd; m_coll = nc;
    endfunction

    // Check every output mid-cycle, advance the model, then step past the edge
    task automatic cycle();
        #1;
        for (int r = 0; r < NRP; r++)
            chk($sformatf("rd%0d", r), bus.rdata_o[r],
                ref_read(int'(bus.rtid_i[r]), int'(bus.raddr_i[r])));
        chk("busy", 32'(bus.clear_busy_o), 32'(m_busy));
        chk("done", 32'(bus.clear_done_o), 32'(m_busy && m_cnt == NREGS - 1));
        chk("drop", 32'(bus.wr_drop_o), 32'(m_drop));
        chk("coll", 32'(bus.collision_o), 32'(m_coll));
        if (bus.clear_busy_o) n_busy++;
        if (bus.clear_done_o) n_done++;
        model_edge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        bus.we_i = '0; bus.waddr_i = '0; bus.wtid_i = '0; bus.wdata_i = '0;
        bus.raddr_i = '0; bus.rtid_i = '0;
        bus.clear_req_i = 1'b0; bus.clear_tid_i = '0;
    endtask

    task automatic set_wr(input int p, input int tid, input int idx, input logic [31:0] d);
        bus.we_i[p] = 1'b1; bus.wtid_i[p] = 1'(tid); bus.waddr_i[p] = 5'(idx); bus.wdata_i[p] = d;
    endtask

    task automatic set_rd(input int r, input int tid, input int idx);
        bus.rtid_i[r] = 1'(tid); bus.raddr_i[r] = 5'(idx);
    endtask

    task automatic sweep_zero(input string tag);
        for (int t = 0; t < NTH; t++)
            for (int i = 0; i < NREGS; i++) begin
                idle_inputs();
                set_rd(0, t, i);
                #1 chk(tag, bus.rdata_o[0], 32'd0);
                cycle();
            end
    endtask

    initial begin
        int nb0, nd0;
        n_checks = 0; n_errors = 0; n_busy = 0; n_done = 0;
        rst_i = 1'b1;
        idle_inputs();
        model_reset();
        @(posedge clk_i); #1;
        cycle();
        rst_i = 1'b0;

        // Simple write then read back on both threads
        idle_inputs(); set_wr(0, 0, 5, 32'hDEADBEEF); cycle();
        idle_inputs(); set_rd(0, 0, 5); set_rd(1, 1, 5);
        #1 chk("t0x5", bus.rdata_o[0], 32'hDEADBEEF);
        chk("t1x5", bus.rdata_o[1], 32'd0);
        cycle();

        // Same-target write on both ports
        idle_inputs(); set_wr(0, 1, 7, 32'h11); set_wr(1, 1, 7, 32'h22); cycle();
        idle_inputs(); set_rd(0, 1, 7);
        #1 chk("coll_val", bus.rdata_o[0], 32'h22);
        chk("coll_flag", 32'(bus.collision_o), 32'd1);
        chk("coll_nodrop", 32'(bus.wr_drop_o), 32'd0);
        cycle();
        #1 chk("coll_once", 32'(bus.collision_o), 32'd0);

        // Same-cycle forwarding
        idle_inputs(); set_wr(0, 0, 3, 32'hA5); set_rd(0, 0, 3);
        #1 chk("bypass", bus.rdata_o[0], 32'hA5);
        cycle();

        // x0 stays zero and its write is not flagged
        idle_inputs(); set_wr(0, 0, 0, 32'hFF); cycle();
        idle_inputs(); set_rd(0, 0, 0);
        #1 chk("x0_read", bus.rdata_o[0], 32'd0);
        chk("x0_nodrop", 32'(bus.wr_drop_o), 32'd0);
        cycle();

        // Fill thread 1, then clear it while probing both banks
        for (int i = 1; i < NREGS; i++) begin
            idle_inputs(); set_wr(0, 1, i, 32'h1000_0000 | 32'(i)); cycle();
        end
        idle_inputs(); set_wr(0, 0, 9, 32'h0BAD0009); cycle();
        idle_inputs(); bus.clear_req_i = 1'b1; bus.clear_tid_i = 1'b1; cycle();
        nb0 = n_busy; nd0 = n_done;
        for (int i = 0; i < 40 && m_busy; i++) begin
            idle_inputs();
            set_rd(0, int'($urandom_range(0, 1)), int'($urandom_range(0, NREGS - 1)));
            if (i == 3) begin
                set_wr(0, 1, 4, 32'h1234); set_wr(1, 0, 9, 32'h5678);
            end
            if (i == 5) begin
                bus.clear_req_i = 1'b1; bus.clear_tid_i = 1'b0;
            end
            cycle();
            if (i == 3) #1 chk("drop_t1", 32'(bus.wr_drop_o), 32'd1);
        end
        chk("busy_cycles", 32'(n_busy - nb0), 32'd32);
        chk("done_pulses", 32'(n_done - nd0), 32'd1);
        idle_inputs(); set_rd(0, 1, 4); set_rd(1, 0, 9);
        #1 chk("t1_cleared", bus.rdata_o[0], 32'd0);
        chk("t0_kept", bus.rdata_o[1], 32'h5678);
        cycle();

        // Randomised traffic with occasional clears
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            for (int p = 0; p < NWP; p++)
                if ($urandom_range(0, 2) != 0)
                    set_wr(p, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), $urandom);
            for (int r = 0; r < NRP; r++) begin
                if ($urandom_range(0, 1) == 1) begin
                    bus.rtid_i[r] = bus.wtid_i[r % NWP]; bus.raddr_i[r] = bus.waddr_i[r % NWP];
                end else begin
                    set_rd(r, int'($urandom_range(0, 1)), int'($urandom_range(0, NREGS - 1)));
                end
            end
            if ($urandom_range(0, 59) == 0) begin
                bus.clear_req_i = 1'b1; bus.clear_tid_i = 1'($urandom_range(0, 1));
            end
            cycle();
        end
        for (int i = 0; i < 40 && m_busy; i++) begin
            idle_inputs(); cycle();
        end

        // Reset in the middle of a clear
        idle_inputs(); set_wr(0, 0, 12, 32'hCAFE0012); set_wr(1, 1, 13, 32'hCAFE0013); cycle();
        idle_inputs(); bus.clear_req_i = 1'b1; bus.clear_tid_i = 1'b0; cycle();
        for (int i = 0; i < 10; i++) begin
            idle_inputs(); cycle();
        end
        nd0 = n_done;
        idle_inputs(); rst_i = 1'b1; cycle();
        rst_i = 1'b0;
        #1 chk("rst_busy", 32'(bus.clear_busy_o), 32'd0);
        chk("rst_done", 32'(bus.clear_done_o), 32'd0);
        sweep_zero("rst_zero");
        chk("rst_no_pulse", 32'(n_done - nd0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/cva6_regfile_mt.md
# cva6_regfile_mt

Parametrised flip-flop register file for multi-threaded CVA6 cores. It holds NR_THREADS independent architectural register banks and provides N read ports, M commit write ports, optional write-to-read bypass, and deterministic same-address write arbitration. A sequential per-thread clear engine zeroes one bank without disturbing the others. It sits between the issue stage (read ports) and commit stage (write ports).

## Interface
- DATA_WIDTH, 32, register width in bits
- NR_REGS, 32, registers per thread (2..64); AW = $clog2(NR_REGS)
- NR_THREADS, 2, banks (1..8); TW = max(1, $clog2(NR_THREADS))
- NR_READ_PORTS, 2, read ports
- NR_WRITE_PORTS, 2, commit write ports
- ZERO_REG_ZERO, 1, register 0 of every bank reads 0 and ignores writes
- BYPASS, 1, same-cycle write data forwarded to matching reads

- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- raddr_i  in  NR_READ_PORTS x AW  read register index
- rtid_i  in  NR_READ_PORTS x TW  read thread id
- rdata_o  out  NR_READ_PORTS x DATA_WIDTH  read data (combinational)
- we_i  in  NR_WRITE_PORTS  write enable
- waddr_i  in  NR_WRITE_PORTS x AW  write register index
- wtid_i  in  NR_WRITE_PORTS x TW  write thread id
- wdata_i  in  NR_WRITE_PORTS x DATA_WIDTH  write data
- clear_req_i  in  1  request to zero one bank
- clear_tid_i  in  TW  bank to clear
- clear_busy_o  out  1  clear engine active
- clear_done_o  out  1  one-cycle pulse, clear finished
- wr_drop_o  out  NR_WRITE_PORTS  registered: port's write was dropped last cycle
- collision_o  out  1  registered: two or more enabled ports targeted the same thread/index last cycle

## Operation
- Storage: NR_THREADS x NR_REGS flops of DATA_WIDTH; written on rising clk_i.
- Reset (rst_i=1 at an edge): all storage 0, FSM IDLE, clear_busy_o=0, clear_done_o=0, wr_drop_o=0, collision_o=0. Reset mid-clear aborts the clear; no done pulse.
- Index >= NR_REGS or tid >= NR_THREADS: write ignored (flagged in wr_drop_o), read returns 0.
- ZERO_REG_ZERO=1: index 0 reads 0; writes to index 0 discarded silently (not flagged).
- Write arbitration: multiple enabled ports with same tid and index -> highest-numbered port wins; others do not write, are not flagged as dropped; collision_o=1 next cycle.
- Read: rdata_o = stored value. With BYPASS=1, an enabled, non-dropped write matching the read's tid/index in the same cycle forwards the winning port's wdata_i. BYPASS=0: old value.
- Clear FSM states IDLE, CLEAR.
  - IDLE: clear_req_i=1 -> latch clear_tid_i, counter=0, go CLEAR.
  - CLEAR: each cycle zero register [tid][counter], counter++. At counter==NR_REGS-1: zero it, assert clear_done_o that cycle, go IDLE.
  - clear_req_i during CLEAR ignored.
  - Writes to the bank being cleared are dropped (wr_drop_o set) while clear_busy_o=1; other banks unaffected. Reads of that bank return stored value (partially cleared contents permitted).
- clear_busy_o = (state==CLEAR).

## Timing
- Read latency 0 (combinational from raddr_i/rtid_i, and from write ports when BYPASS=1).
- Write visible to non-bypassed reads the cycle after the edge.
- Clear: request at edge T -> busy from T+1; register k zeroed at edge T+1+k; clear_done_o high during cycle T+NR_REGS; busy low from T+NR_REGS+1; new request accepted then. Total NR_REGS busy cycles.
- wr_drop_o, collision_o reflect the previous cycle, valid for one cycle.

## Test plan
- Reset then write T0 x5=0xDEADBEEF via port 0 -> next cycle read port 0 (T0,x5) = 0xDEADBEEF; (T1,x5) = 0.
- Ports 0 and 1 both write T1 x7 (0x11, 0x22) -> x7=0x22; collision_o=1 for exactly one cycle; wr_drop_o=0.
- BYPASS=1: write T0 x3=0xA5 and read T0 x3 same cycle -> rdata=0xA5; BYPASS=0 build -> old value 0.
- Write T0 x0=0xFF with ZERO_REG_ZERO=1 -> reads 0, wr_drop_o=0.
- Fill T1 x1..x31 nonzero, clear_req T1 -> busy 32 cycles, done pulse once, all T1 reads 0, T0 untouched; write to T1 during busy -> wr_drop_o=1, value not stored; write to T0 during busy succeeds.
- Assert rst_i at clear cycle 10 -> busy=0, no done pulse, all registers 0.
